uart_reg_responder: RTL and testbench

- Byte-level command responder on the far end of the UART link.
- Consumes received bytes from the UART receiver (dout_rx/done_rx) and decodes read/write commands from a host initiator.
- Performs single-byte register accesses on a simple local register bus.
- Returns ACK, NAK or read data through the UART transmitter (din_tx/data_update/done_tx).

---
 rtl/uart_resp_pkg.sv | 31 +++
 rtl/uart_timeout_ctr.sv | 45 ++++
 rtl/uart_reg_responder.sv | 178 +++++++++++++++++
 tb/tb_uart_reg_responder.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_resp_pkg.sv
// Shared definitions for the UART register responder.
//   state_e        : responder FSM states
//   ACK / NAK      : response bytes returned to the host
//   CMD_*_DFLT     : default write/read command bytes
package uart_resp_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] ACK         = 8'h06;
  localparam logic [BYTE_W-1:0] NAK         = 8'h15;
  localparam logic [BYTE_W-1:0] CMD_WR_DFLT = 8'h57;  // 'W'
  localparam logic [BYTE_W-1:0] CMD_RD_DFLT = 8'h52;  // 'R'

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_DATA     = 3'd2,
    ST_ACCESS   = 3'd3,
    ST_RD_CAP   = 3'd4,
    ST_TX_START = 3'd5,
    ST_TX_WAIT  = 3'd6
  } state_e;

  // True when a first byte opens a recognised command.
  function automatic logic is_cmd(input logic [BYTE_W-1:0] b,
                                  input logic [BYTE_W-1:0] wr,
                                  input logic [BYTE_W-1:0] rd);
    return (b == wr) || (b == rd);
  endfunction

endpackage

// File: rtl/uart_timeout_ctr.sv
// Inter-byte timeout counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : force the count back to zero (has priority over en_i)
//   en_i       : advance the count by one per cycle
//   expire_o   : high while the count sits at TIMEOUT_CYCLES-1
module uart_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 4167
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          expire_q;

  // Next count: saturates at LAST so a stalled consumer never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // expire_q tracks cnt_q == LAST, registered together with the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= en_i && !clr_i && (cnt_d == LAST);
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/uart_reg_responder.sv
// Byte-level command responder behind a UART receiver/transmitter pair.
// Decodes W,addr,data (write) and R,addr (read) commands, performs a single
// register access and answers ACK, ACK+data, or NAK for unknown commands.
//   clk, rst_n          : clock, asynchronous active-low reset
//   rx_data, rx_valid   : received byte and its one-cycle strobe
//   tx_data, tx_start   : byte to send and its one-cycle start pulse
//   tx_done             : transmitter finished the current byte
//   reg_addr, reg_wdata : register bus address / write data
//   reg_we, reg_re      : one-cycle write / read strobes
//   reg_rdata           : read data, valid the cycle after reg_re
//   busy                : FSM not idle
//   timeout             : pulse when a partial command is abandoned
//   rx_drop             : pulse when a byte arrives while responding
module uart_reg_responder
  import uart_resp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4167,
  parameter logic [7:0]  CMD_WR         = CMD_WR_DFLT,
  parameter logic [7:0]  CMD_RD         = CMD_RD_DFLT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_done,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       timeout,
  output logic       rx_drop
);

  state_e     state_q;
  logic [7:0] cmd_q;
  logic [7:0] hold_q;     // read data waiting to go out as the second byte
  logic       pend_q;     // second response byte still owed
  logic       rd_cap_q;   // reg_rdata is valid this cycle

  logic tmr_en_c;
  logic tmr_clr_c;
  logic tmr_expire;

  // Timer only runs while a command is partially received.
  always_comb begin
    tmr_en_c  = (state_q == ST_ADDR) || (state_q == ST_DATA);
    tmr_clr_c = rx_valid || !tmr_en_c;
  end

  uart_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (tmr_clr_c),
    .en_i     (tmr_en_c),
    .expire_o (tmr_expire)
  );

  // Responder FSM and datapath; every output is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      hold_q    <= '0;
      pend_q    <= 1'b0;
      rd_cap_q  <= 1'b0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
      rx_drop   <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      reg_we   <= 1'b0;
      reg_re   <= 1'b0;
      timeout  <= 1'b0;
      rx_drop  <= 1'b0;

      // Read data arrives one cycle after the visible reg_re strobe.
      rd_cap_q <= reg_re;
      if (rd_cap_q) begin
        hold_q <= reg_rdata;
      end

      case (state_q)
        ST_IDLE: begin
          if (rx_valid) begin
            busy <= 1'b1;
            if (is_cmd(rx_data, CMD_WR, CMD_RD)) begin
              cmd_q   <= rx_data;
              state_q <= ST_ADDR;
            end else begin
              tx_data <= NAK;
              state_q <= ST_TX_START;
            end
          end
        end

        ST_ADDR: begin
          // A byte in the expiry cycle wins over the timeout.
          if (rx_valid) begin
            reg_addr <= rx_data;
            state_q  <= (cmd_q == CMD_WR) ? ST_DATA : ST_ACCESS;
          end else if (tmr_expire) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        ST_DATA: begin
          if (rx_valid) begin
            reg_wdata <= rx_data;
            state_q   <= ST_ACCESS;
          end else if (tmr_expire) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        ST_ACCESS: begin
          rx_drop <= rx_valid;
          if (cmd_q == CMD_WR) begin
            reg_we  <= 1'b1;
            tx_data <= ACK;
            state_q <= ST_TX_START;
          end else begin
            reg_re  <= 1'b1;
            state_q <= ST_RD_CAP;
          end
        end

        ST_RD_CAP: begin
          rx_drop <= rx_valid;
          pend_q  <= 1'b1;
          tx_data <= ACK;
          state_q <= ST_TX_START;
        end

        ST_TX_START: begin
          rx_drop  <= rx_valid;
          tx_start <= 1'b1;
          state_q  <= ST_TX_WAIT;
        end

        ST_TX_WAIT: begin
          rx_drop <= rx_valid;
          if (tx_done) begin
            if (pend_q) begin
              pend_q  <= 1'b0;
              tx_data <= hold_q;
              state_q <= ST_TX_START;
            end else begin
              busy    <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end

        default: begin
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_responder.sv
// Self-checking bench for uart_reg_responder: directed scenarios followed by
// randomized command traffic, checked against a command-level model.
module tb_uart_reg_responder;

  localparam int unsigned T        = 50;
  localparam int unsigned DONE_LAT = 20;
  localparam logic [7:0]  ACK_B    = 8'h06;
  localparam logic [7:0]  NAK_B    = 8'h15;
  localparam logic [7:0]  CMD_W    = 8'h57;
  localparam logic [7:0]  CMD_R    = 8'h52;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_done;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       timeout;
  logic       rx_drop;

  always #5 clk = ~clk;

  uart_reg_responder #(.TIMEOUT_CYCLES(T)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_done   (tx_done),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .timeout   (timeout),
    .rx_drop   (rx_drop)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // Register-side device memory and the model's view of it.
  logic [7:0]  slave_mem [256];
  logic [7:0]  model_mem [256];

  // Observed events.
  logic [15:0] we_q[$];
  int          we_cyc_q[$];
  logic [7:0]  re_q[$];
  int          re_cyc_q[$];
  logic [7:0]  tx_q[$];
  int          tx_cyc_q[$];
  int          to_cyc_q[$];
  int          n_drop = 0;
  int          done_cyc = 0;
  int          busy_fall_cyc = 0;
  int          stab_err = 0;

  // Expectations for the current transaction.
  logic [15:0] e_we[$];
  logic [7:0]  e_re[$];
  logic [7:0]  e_tx[$];
  int          e_to, e_drop;
  int          b_we, b_re, b_tx, b_to, b_drop;
  int          last_rx = 0;

  // Environment: register device, transmitter model and event monitor.
  initial begin
    bit         prev_busy = 1'b0;
    bit         re_seen   = 1'b0;
    bit         track     = 1'b0;
    logic [7:0] re_addr   = 8'h00;
    logic [7:0] held      = 8'h00;
    int         cd        = 0;
    tx_done   = 1'b0;
    reg_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      reg_rdata = re_seen ? slave_mem[re_addr] : 8'($urandom);
      re_seen   = reg_re;
      re_addr   = reg_addr;
      if (reg_we) begin
        slave_mem[reg_addr] = reg_wdata;
        we_q.push_back({reg_addr, reg_wdata});
        we_cyc_q.push_back(cyc);
      end
      if (reg_re) begin
        re_q.push_back(reg_addr);
        re_cyc_q.push_back(cyc);
      end
      if (timeout) to_cyc_q.push_back(cyc);
      if (rx_drop) n_drop++;
      if (prev_busy && !busy) busy_fall_cyc = cyc;
      prev_busy = busy;
      if (!rst_n) track = 1'b0;
      if (track && (tx_data !== held)) stab_err++;
      tx_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          tx_done  = 1'b1;
          done_cyc = cyc;
          track    = 1'b0;
        end
      end
      if (tx_start) begin
        tx_q.push_back(tx_data);
        tx_cyc_q.push_back(cyc);
        held  = tx_data;
        track = 1'b1;
        cd    = DONE_LAT;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] at16(input logic [15:0] q[$], input int i);
    return (i < q.size()) ? 32'(q[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] at8(input logic [7:0] q[$], input int i);
    return (i < q.size()) ? 32'(q[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ati(input int q[$], input int i);
    return (i < q.size()) ? 32'(q[i]) : 32'hFFFF_FFFF;
  endfunction

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clk);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    last_rx  = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // Deliver a byte so that rx_valid is high in cycle t.
  task automatic send_at(input logic [7:0] b, input int t);
    repeat (t - cyc - 1) @(posedge clk);
    send(b, 0);
  endtask

  task automatic wait_tx(input string tag);
    int n = 0;
    while (tx_q.size() == b_tx && n < 200) begin @(posedge clk); #1; n++; end
    chk({tag, " first_tx_seen"}, 32'(tx_q.size() - b_tx), 32'd1);
  endtask

  task automatic begin_txn();
    e_we.delete(); e_re.delete(); e_tx.delete();
    e_to = 0; e_drop = 0;
    b_we = we_q.size(); b_re = re_q.size(); b_tx = tx_q.size();
    b_to = to_cyc_q.size(); b_drop = n_drop;
  endtask

  task automatic end_txn(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin @(posedge clk); #1; n++; end
    chk({tag, " idle_reached"}, 32'(busy), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    chk({tag, " we_count"}, 32'(we_q.size() - b_we), 32'(e_we.size()));
    foreach (e_we[i]) chk({tag, " we_addr_data"}, at16(we_q, b_we + i), 32'(e_we[i]));
    chk({tag, " re_count"}, 32'(re_q.size() - b_re), 32'(e_re.size()));
    foreach (e_re[i]) chk({tag, " re_addr"}, at8(re_q, b_re + i), 32'(e_re[i]));
    chk({tag, " tx_count"}, 32'(tx_q.size() - b_tx), 32'(e_tx.size()));
    foreach (e_tx[i]) chk({tag, " tx_byte"}, at8(tx_q, b_tx + i), 32'(e_tx[i]));
    chk({tag, " timeouts"}, 32'(to_cyc_q.size() - b_to), 32'(e_to));
    chk({tag, " drops"}, 32'(n_drop - b_drop), 32'(e_drop));
  endtask

  // Model: W,a,d writes d to a and answers ACK.
  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int gap, input string tag);
    int lr;
    begin_txn();
    send(CMD_W, gap); send(a, gap); send(d, gap);
    lr = last_rx;
    model_mem[a] = d;
    e_we.push_back({a, d});
    e_tx.push_back(ACK_B);
    end_txn(tag);
    chk({tag, " we_latency"}, ati(we_cyc_q, b_we), 32'(lr + 2));
    chk({tag, " tx_latency"}, ati(tx_cyc_q, b_tx), 32'(lr + 3));
  endtask

  // Model: R,a answers ACK then the stored byte at a.
  task automatic do_read(input logic [7:0] a, input int gap, input string tag);
    int lr;
    begin_txn();
    send(CMD_R, gap); send(a, gap);
    lr = last_rx;
    e_re.push_back(a);
    e_tx.push_back(ACK_B);
    e_tx.push_back(model_mem[a]);
    end_txn(tag);
    chk({tag, " re_latency"}, ati(re_cyc_q, b_re), 32'(lr + 2));
    chk({tag, " tx_latency"}, ati(tx_cyc_q, b_tx), 32'(lr + 4));
  endtask

  // Model: any other first byte answers NAK.
  task automatic do_bad(input logic [7:0] b, input string tag);
    int lr;
    begin_txn();
    send(b, 0);
    lr = last_rx;
    e_tx.push_back(NAK_B);
    end_txn(tag);
    chk({tag, " tx_latency"}, ati(tx_cyc_q, b_tx), 32'(lr + 2));
  endtask

  // Model: an abandoned command times out T+1 cycles after its last byte.
  task automatic do_partial(input bit with_addr, input string tag);
    int lr;
    begin_txn();
    if (with_addr) begin
      send(CMD_W, 0); send(8'($urandom), 0);
    end else begin
      send(CMD_R, 0);
    end
    lr = last_rx;
    e_to = 1;
    end_txn(tag);
    chk({tag, " timeout_cycle"}, ati(to_cyc_q, b_to), 32'(lr + T + 1));
  endtask

  initial begin
    logic [7:0] v;
    int         lr;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      slave_mem[i] = v;
      model_mem[i] = v;
    end
    slave_mem[8'h22] = 8'h3C;
    model_mem[8'h22] = 8'h3C;

    rst_n    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("reset outputs", {tx_data, reg_addr, reg_wdata, tx_start, reg_we, reg_re, busy, timeout, rx_drop}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Write with ACK; busy falls the cycle after tx_done; registers hold.
    do_write(8'h10, 8'hA5, 0, "t1_write");
    chk("t1 busy_fall", 32'(busy_fall_cyc), 32'(done_cyc + 1));
    chk("t1 idle_hold", {8'h00, reg_addr, reg_wdata, tx_data}, {8'h00, 8'h10, 8'hA5, ACK_B});

    do_read(8'h22, 0, "t2_read");
    do_bad(8'h41, "t3_nak");
    do_partial(1'b1, "t4_timeout");
    do_read(8'h05, 0, "t4_read_after");

    // Byte arriving while the write ACK is in flight is dropped.
    begin_txn();
    send(CMD_W, 0); send(8'h44, 0); send(8'h5A, 0);
    model_mem[8'h44] = 8'h5A;
    e_we.push_back({8'h44, 8'h5A});
    e_tx.push_back(ACK_B);
    wait_tx("t5");
    repeat (5) @(posedge clk);
    send(8'h99, 0);
    e_drop = 1;
    end_txn("t5_drop");

    // Reset between the read ACK and its data byte.
    begin_txn();
    send(CMD_R, 0); send(8'h33, 0);
    e_re.push_back(8'h33);
    e_tx.push_back(ACK_B);
    wait_tx("t6");
    repeat (5) @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t6 outputs_in_reset", {tx_data, reg_addr, reg_wdata, tx_start, reg_we, reg_re, busy, timeout, rx_drop}, 32'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (40) @(posedge clk); #1;
    end_txn("t6_reset");
    do_write(8'h01, 8'h02, 0, "t6_write_after");

    // Byte landing exactly in the expiry cycle is accepted.
    begin_txn();
    send(CMD_W, 0); send(8'h60, 0);
    lr = last_rx;
    send_at(8'h61, lr + T);
    model_mem[8'h60] = 8'h61;
    e_we.push_back({8'h60, 8'h61});
    e_tx.push_back(ACK_B);
    end_txn("t7_expiry_edge");

    // One cycle later the command is already abandoned; the byte is a new command.
    begin_txn();
    send(CMD_W, 0); send(8'h62, 0);
    lr = last_rx;
    send_at(8'hA5, lr + T + 1);
    e_to = 1;
    e_tx.push_back(NAK_B);
    end_txn("t8_past_expiry");
    chk("t8 timeout_cycle", ati(to_cyc_q, b_to), 32'(lr + T + 1));

    do_partial(1'b0, "t9_timeout_addr");

    // Randomized command traffic.
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 4))
        0, 1: do_write(8'($urandom), 8'($urandom), $urandom_range(0, 3), "rnd_write");
        2, 3: do_read(8'($urandom), $urandom_range(0, 3), "rnd_read");
        default: begin
          do v = 8'($urandom); while (v == CMD_W || v == CMD_R);
          do_bad(v, "rnd_nak");
        end
      endcase
    end

    chk("tx_data_stable", 32'(stab_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
